// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
// The FSM, the request record and the data/address widths are defined here.
package dmem_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // A request as captured at acceptance and replayed while the access is in flight.
  typedef struct packed {
    op_t               op;
    logic              op_err;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 8 register storage: synchronous write, combinational read,
// synchronous clear of every word on reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: every word is cleared on reset because a read after reset must return
  // 0x00; this forces flops rather than a RAM macro, which is acceptable at this size.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory slave with configurable read/write latency and a
// pipeline stall that covers the whole access until the response cycle.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              resp_valid,
  output logic              stall,
  output logic              addr_err,
  output logic              op_err
);

  localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] RD_CNT    = 4'(READ_LAT - 1);
  localparam logic [3:0] WR_CNT    = 4'(WRITE_LAT - 1);
  localparam logic [8:0] DEPTH_LIM = 9'(DEPTH);

  state_t            state;
  logic [3:0]        counter;
  req_t              req_q;
  req_t              req_in;
  req_t              req_cur;
  logic              request;
  logic [3:0]        start_cnt;
  logic              finish;
  logic              in_range;
  logic              arr_we;
  logic [DATA_W-1:0] arr_rdata;

  assign request = mem_read | mem_write;

  // NOTE: each signal written here gets a value on every path (defaults first),
  // so the block stays purely combinational and no latch is inferred.
  always_comb begin
    req_in    = '{op: op_t'(mem_write), op_err: mem_read & mem_write,
                  addr: address, data: write_data};
    start_cnt = (req_in.op == OP_WRITE) ? WR_CNT : RD_CNT;
    // A latency-1 access completes on its acceptance edge, before req_q is loaded.
    req_cur   = (state == IDLE) ? req_in : req_q;
    finish    = 1'b0;
    if (state == IDLE && request && start_cnt == 4'd0) finish = 1'b1;
    if (state == BUSY && counter == 4'd1)              finish = 1'b1;
    in_range  = {1'b0, req_cur.addr} < DEPTH_LIM;
    arr_we    = finish && req_cur.op == OP_WRITE && in_range;
    stall     = (state == IDLE && request) || state == BUSY;
  end

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clock (clock),
    .reset (reset),
    .we    (arr_we),
    .addr  (req_cur.addr[IDX_W-1:0]),
    .wdata (req_cur.data),
    .rdata (arr_rdata)
  );

  // NOTE: state and registered outputs use non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      counter    <= '0;
      req_q      <= '0;
      read_data  <= '0;
      resp_valid <= 1'b0;
      addr_err   <= 1'b0;
      op_err     <= 1'b0;
    end else begin
      resp_valid <= finish;
      addr_err   <= finish & ~in_range;
      op_err     <= finish & req_cur.op_err;
      if (finish && req_cur.op == OP_READ)
        read_data <= in_range ? arr_rdata : '0;

      case (state)
        IDLE: if (request) begin
          req_q   <= req_in;
          counter <= start_cnt;
          state   <= (start_cnt == 4'd0) ? DONE : BUSY;
        end
        BUSY: begin
          counter <= counter - 4'd1;
          if (counter == 4'd1) state <= DONE;
        end
        // Inputs still show the completed request here, so they are ignored.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a default instance (DEPTH=256) and a
// DEPTH=16 / WRITE_LAT=3 instance selected by sel16.
module tb_dmem_responder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       mem_read = 1'b0, mem_write = 1'b0;
  logic [7:0] address = '0, write_data = '0;
  logic       sel16 = 1'b0;

  logic [7:0] rd_a, rd_b;
  logic       rv_a, st_a, ae_a, oe_a, rv_b, st_b, ae_b, oe_b;
  logic       mr_b, mw_b;

  logic [7:0] o_rd;
  logic       o_rv, o_st, o_ae, o_oe;

  int pass_cnt = 0, total_cnt = 0;
  int sn, rn;
  logic sd, ae, oe;
  logic [7:0] rdat;

  always #5 clock = ~clock;

  assign mr_b = mem_read & sel16;
  assign mw_b = mem_write & sel16;
  assign o_rd = sel16 ? rd_b : rd_a;
  assign o_rv = sel16 ? rv_b : rv_a;
  assign o_st = sel16 ? st_b : st_a;
  assign o_ae = sel16 ? ae_b : ae_a;
  assign o_oe = sel16 ? oe_b : oe_a;

  dmem_responder dut (
    .clock(clock), .reset(reset), .mem_read(mem_read & ~sel16), .mem_write(mem_write & ~sel16),
    .address(address), .write_data(write_data), .read_data(rd_a), .resp_valid(rv_a),
    .stall(st_a), .addr_err(ae_a), .op_err(oe_a)
  );

  dmem_responder #(.DEPTH(16), .READ_LAT(2), .WRITE_LAT(3)) dut16 (
    .clock(clock), .reset(reset), .mem_read(mr_b), .mem_write(mw_b),
    .address(address), .write_data(write_data), .read_data(rd_b), .resp_valid(rv_b),
    .stall(st_b), .addr_err(ae_b), .op_err(oe_b)
  );

  // Drives one request and records stall cycles before the response, the
  // response cycle index (request cycle = 0, -1 on timeout) and the response outputs.
  task automatic do_access(input logic rd, input logic wr, input logic [7:0] addr,
                           input logic [7:0] data, input bit hold,
                           output int stall_n, output int resp_n, output logic stall_done,
                           output logic [7:0] rdata, output logic aerr, output logic oerr);
    mem_read = rd; mem_write = wr; address = addr; write_data = data;
    stall_n = 0; resp_n = -1; stall_done = 1'bx; rdata = 'x; aerr = 1'bx; oerr = 1'bx;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (o_rv) begin
        resp_n = n; stall_done = o_st; rdata = o_rd; aerr = o_ae; oerr = o_oe;
        break;
      end
      if (o_st) stall_n++;
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
    if (!hold) begin mem_read = 1'b0; mem_write = 1'b0; end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    if (o_rd !== 8'h00) $display("FAIL reset_read_data got=%h exp=00", o_rd); else pass_cnt++; total_cnt++;
    if (o_rv !== 1'b0) $display("FAIL reset_resp_valid got=%b exp=0", o_rv); else pass_cnt++; total_cnt++;
    if (o_st !== 1'b0) $display("FAIL reset_stall got=%b exp=0", o_st); else pass_cnt++; total_cnt++;
    if ({o_ae, o_oe} !== 2'b00) $display("FAIL reset_errs got=%b exp=00", {o_ae, o_oe}); else pass_cnt++; total_cnt++;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_read_latency();
    do_access(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, sn, rn, sd, rdat, ae, oe);
    if (sn !== 2) $display("FAIL rd10_stall_cycles got=%0d exp=2", sn); else pass_cnt++; total_cnt++;
    if (rn !== 2) $display("FAIL rd10_resp_cycle got=%0d exp=2", rn); else pass_cnt++; total_cnt++;
    if (sd !== 1'b0) $display("FAIL rd10_stall_in_done got=%b exp=0", sd); else pass_cnt++; total_cnt++;
    if (rdat !== 8'h00) $display("FAIL rd10_data got=%h exp=00", rdat); else pass_cnt++; total_cnt++;
    @(negedge clock);
    if (o_rv !== 1'b0) $display("FAIL rd10_pulse_width got=%b exp=0", o_rv); else pass_cnt++; total_cnt++;
    @(posedge clock); #1;
  endtask

  task automatic test_write_read();
    do_access(1'b0, 1'b1, 8'h20, 8'hA5, 1'b0, sn, rn, sd, rdat, ae, oe);
    if (sn !== 1) $display("FAIL wr20_stall_cycles got=%0d exp=1", sn); else pass_cnt++; total_cnt++;
    if (rn !== 1) $display("FAIL wr20_resp_cycle got=%0d exp=1", rn); else pass_cnt++; total_cnt++;
    do_access(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, sn, rn, sd, rdat, ae, oe);
    if (rn !== 2) $display("FAIL rd20_resp_cycle got=%0d exp=2", rn); else pass_cnt++; total_cnt++;
    if (rdat !== 8'hA5) $display("FAIL rd20_data got=%h exp=a5", rdat); else pass_cnt++; total_cnt++;
    @(negedge clock);
    if (o_rd !== 8'hA5) $display("FAIL rd20_data_hold got=%h exp=a5", o_rd); else pass_cnt++; total_cnt++;
    @(posedge clock); #1;
  endtask

  task automatic test_hold_through_done();
    do_access(1'b1, 1'b0, 8'h20, 8'h00, 1'b1, sn, rn, sd, rdat, ae, oe);
    if (rn !== 2) $display("FAIL hold_first_resp got=%0d exp=2", rn); else pass_cnt++; total_cnt++;
    @(negedge clock);
    if ({o_rv, o_st} !== 2'b01) $display("FAIL hold_idle_reaccept got=%b exp=01", {o_rv, o_st}); else pass_cnt++; total_cnt++;
    @(posedge clock); #1;
    @(negedge clock);
    if (o_rv !== 1'b0) $display("FAIL hold_no_duplicate got=%b exp=0", o_rv); else pass_cnt++; total_cnt++;
    @(posedge clock); #1;
    @(negedge clock);
    if (o_rv !== 1'b1) $display("FAIL hold_second_resp got=%b exp=1", o_rv); else pass_cnt++; total_cnt++;
    @(posedge clock); #1;
    mem_read = 1'b0;
    @(negedge clock);
    if ({o_rv, o_st} !== 2'b00) $display("FAIL hold_release got=%b exp=00", {o_rv, o_st}); else pass_cnt++; total_cnt++;
    @(posedge clock); #1;
  endtask

  task automatic test_op_err();
    do_access(1'b1, 1'b1, 8'h05, 8'h3C, 1'b0, sn, rn, sd, rdat, ae, oe);
    if (rn !== 1) $display("FAIL both_resp_cycle got=%0d exp=1", rn); else pass_cnt++; total_cnt++;
    if ({oe, ae} !== 2'b10) $display("FAIL both_op_err got=%b exp=10", {oe, ae}); else pass_cnt++; total_cnt++;
    do_access(1'b1, 1'b0, 8'h05, 8'h00, 1'b0, sn, rn, sd, rdat, ae, oe);
    if (rdat !== 8'h3C) $display("FAIL rd05_data got=%h exp=3c", rdat); else pass_cnt++; total_cnt++;
    if (oe !== 1'b0) $display("FAIL rd05_op_err got=%b exp=0", oe); else pass_cnt++; total_cnt++;
  endtask

  task automatic test_addr_err();
    sel16 = 1'b1;
    do_access(1'b0, 1'b1, 8'h0F, 8'h5A, 1'b0, sn, rn, sd, rdat, ae, oe);
    if (sn !== 3) $display("FAIL d16_wr0f_stall got=%0d exp=3", sn); else pass_cnt++; total_cnt++;
    if (rn !== 3) $display("FAIL d16_wr0f_resp got=%0d exp=3", rn); else pass_cnt++; total_cnt++;
    if (ae !== 1'b0) $display("FAIL d16_wr0f_addr_err got=%b exp=0", ae); else pass_cnt++; total_cnt++;
    do_access(1'b0, 1'b1, 8'h30, 8'h77, 1'b0, sn, rn, sd, rdat, ae, oe);
    if (ae !== 1'b1) $display("FAIL d16_wr30_addr_err got=%b exp=1", ae); else pass_cnt++; total_cnt++;
    do_access(1'b1, 1'b0, 8'h0F, 8'h00, 1'b0, sn, rn, sd, rdat, ae, oe);
    if (rdat !== 8'h5A) $display("FAIL d16_rd0f_data got=%h exp=5a", rdat); else pass_cnt++; total_cnt++;
    do_access(1'b1, 1'b0, 8'h30, 8'h00, 1'b0, sn, rn, sd, rdat, ae, oe);
    if (ae !== 1'b1) $display("FAIL d16_rd30_addr_err got=%b exp=1", ae); else pass_cnt++; total_cnt++;
    if (rdat !== 8'h00) $display("FAIL d16_rd30_data got=%h exp=00", rdat); else pass_cnt++; total_cnt++;
    do_access(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, sn, rn, sd, rdat, ae, oe);
    if (rdat !== 8'h00) $display("FAIL d16_rd00_no_wrap got=%h exp=00", rdat); else pass_cnt++; total_cnt++;
  endtask

  task automatic test_reset_abort();
    sel16 = 1'b1;
    mem_write = 1'b1; address = 8'h08; write_data = 8'hFF;
    @(negedge clock);
    if (o_st !== 1'b1) $display("FAIL abort_stall_req got=%b exp=1", o_st); else pass_cnt++; total_cnt++;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    if (o_st !== 1'b1) $display("FAIL abort_stall_busy got=%b exp=1", o_st); else pass_cnt++; total_cnt++;
    @(posedge clock); #1;
    reset = 1'b0; mem_write = 1'b0;
    @(negedge clock);
    if ({o_rv, o_st} !== 2'b00) $display("FAIL abort_after_reset got=%b exp=00", {o_rv, o_st}); else pass_cnt++; total_cnt++;
    @(posedge clock); #1;
    @(negedge clock);
    if (o_rv !== 1'b0) $display("FAIL abort_no_resp got=%b exp=0", o_rv); else pass_cnt++; total_cnt++;
    @(posedge clock); #1;
    do_access(1'b1, 1'b0, 8'h08, 8'h00, 1'b0, sn, rn, sd, rdat, ae, oe);
    if (rn !== 2) $display("FAIL abort_rd08_resp got=%0d exp=2", rn); else pass_cnt++; total_cnt++;
    if (rdat !== 8'h00) $display("FAIL abort_rd08_data got=%h exp=00", rdat); else pass_cnt++; total_cnt++;
    sel16 = 1'b0;
    do_access(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, sn, rn, sd, rdat, ae, oe);
    if (rdat !== 8'h00) $display("FAIL reset_clears_array got=%h exp=00", rdat); else pass_cnt++; total_cnt++;
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_write_read();
    test_hold_through_done();
    test_op_err();
    test_addr_err();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout passed=%0d total=%0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the 8-bit RISC-V pipeline. It is the slave end of the MEM-stage interface: it accepts mem_read/mem_write requests, stores 8-bit data and answers reads.
- It adds configurable multi-cycle access latency and raises a stall signal, so the hazard unit can freeze IF..MEM while an access is in flight.
- It replaces the single-cycle data memory behind MEM when slower memory timing is modelled.

Parameters:
- DEPTH, 256, number of 8-bit words (1..256); valid addresses are 0..DEPTH-1.
- READ_LAT, 2, cycles from request acceptance to read data valid (1..15).
- WRITE_LAT, 1, cycles from request acceptance to write commit (1..15).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_read  in  1  read request, held by MEM until the pipeline advances.
- mem_write  in  1  write request, held likewise.
- address  in  8  word address (ALU result).
- write_data  in  8  data to store.
- read_data  out  8  read result, valid while resp_valid=1.
- resp_valid  out  1  one-cycle pulse: access complete.
- stall  out  1  freeze the pipeline upstream of and including MEM.
- addr_err  out  1  one-cycle pulse with resp_valid when address >= DEPTH.
- op_err  out  1  one-cycle pulse with resp_valid when mem_read and mem_write were both asserted at acceptance.

Behaviour:
- Reset (synchronous, active-high), on the edge where reset=1:
  - state=IDLE, counter=0, all array words=0x00.
  - read_data=0x00; resp_valid, stall, addr_err and op_err all 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - A request is mem_read|mem_write.
  - stall = request, combinationally in the same cycle, so the pipeline holds.
  - On the clock edge with a request, the block latches address, write_data and op. Op is WRITE if mem_write=1, else READ; write has priority, and op_err is latched if both are asserted.
  - counter <= LAT-1 for the selected op.
  - Next state is BUSY if LAT>1, else DONE.
- BUSY:
  - stall=1.
  - counter decrements each cycle; at 0 the state moves to DONE.
  - Input changes are ignored.
- Entry to DONE (registered on that edge):
  - WRITE: array[addr] <= data if addr<DEPTH; the write is dropped otherwise.
  - READ: read_data <= array[addr], or 0x00 if addr>=DEPTH.
- DONE (exactly one cycle):
  - resp_valid=1, stall=0, so the pipeline advances at the end of this cycle.
  - addr_err and op_err pulse here if latched.
  - Request inputs are ignored in DONE, because they still carry the old, completed request.
  - Next state is unconditionally IDLE.
- read_data holds its last value outside DONE. It changes only on a read completion or on reset.
- Total visible latency: a request first seen in cycle t gives resp_valid in cycle t+LAT. stall is high for cycles t..t+LAT-1.
- Back-to-back requests: the next request is accepted in the IDLE cycle after DONE, with no bubble beyond that.
- Read-after-write to the same address returns the new data, since the write committed before DONE.
- Reset mid-operation (BUSY or DONE) aborts the access: no commit, no resp_valid, state IDLE.
- Address width is a fixed 8 bits. The array index uses address directly, with no wrap. The out-of-range check applies only when DEPTH<256.

Decomposition:
- Package dmem_pkg:
  - state encoding constants (IDLE=2'd0, BUSY=2'd1, DONE=2'd2)
  - op encoding (OP_READ=1'b0, OP_WRITE=1'b1)
  - DATA_W=8, ADDR_W=8
- Sub-module dmem_array: DEPTH x 8 register storage with synchronous write enable, combinational read port and synchronous reset-to-zero.
- The FSM and latency counter stay in dmem_responder.

Test Plan:
- Reset, then READ_LAT=2, read addr 0x10 -> stall=1 for 2 cycles, resp_valid pulse in cycle 3 with read_data=0x00.
- Write 0xA5 to addr 0x20 (WRITE_LAT=1), then read 0x20 -> write: stall 1 cycle, resp_valid next cycle. Read: read_data=0xA5, resp_valid 2 cycles after acceptance.
- Hold the same read request through DONE -> exactly one resp_valid; the next access is accepted only from IDLE, and no duplicate response occurs.
- mem_read=mem_write=1, addr 0x05, data 0x3C -> treated as write, op_err pulses with resp_valid, and a later read of 0x05 returns 0x3C.
- DEPTH=16, write 0x77 to addr 0x30, then read 0x30 -> addr_err pulses on both accesses, the write is dropped and read_data=0x00.
- Assert reset during BUSY of a write of 0xFF to 0x08 -> no resp_valid, stall=0 next cycle, and a later read of 0x08 returns 0x00.
